// File: rtl/channel_arbiter.sv
// -----------------------------------------------------------------------------
// channel_arbiter
//
// Packet-granular round-robin arbiter that sits directly downstream of a bank
// of CH_NUM channel buffers. It watches each buffer's ctrl_ready / ctrl_eop,
// drives a one-hot ctrl_sel back to the buffers, and muxes the selected
// buffer's output stream onto one registered output bus. A granted packet is
// never interrupted: the grant is released only on that buffer's ctrl_eop
// (or, with ARB_TIMEOUT_EN, by the watchdog).
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : a watchdog counter runs while a grant is held. After
//               TIMEOUT_CYC cycles without ctrl_eop the grant is dropped and
//               o_timeout pulses for one cycle. No synthetic eop is emitted.
//   undefined : no counter, o_timeout tied to 0, a grant is held until eop.
//
// Ports
//   clock      in   system clock
//   reset      in   asynchronous, active-high reset
//   i_busy     in   downstream busy; blocks new grants only
//   ch_ready   in   [CH_NUM]   per-channel ctrl_ready (complete packet held)
//   ch_eop     in   [CH_NUM]   per-channel ctrl_eop (eop beat this cycle)
//   ch_sel     out  [CH_NUM]   one-hot grant to each buffer's ctrl_sel
//   ch_sop     in   [CH_NUM]   per-channel o_sop
//   ch_eop_d   in   [CH_NUM]   per-channel o_eop
//   ch_valid   in   [CH_NUM]   per-channel o_valid
//   ch_data    in   [CH_NUM*DATA_WIDTH] flattened o_data, ch i at i*DATA_WIDTH
//   ch_bytes   in   [CH_NUM*4] flattened o_bytes
//   ch_error   in   [CH_NUM]   per-channel o_error
//   o_sop/o_eop/o_valid/o_data/o_bytes/o_error  out  merged, registered beat
//   o_chan     out  [CH_WIDTH] source channel of the current beat
//   o_timeout  out  one-cycle watchdog pulse
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+---------------------------------------------------------------------
// IDLE  | no grant; arbitrate among ready channels when downstream not busy
// XFER  | grant held on sel_idx; beats forwarded until ctrl_eop (or watchdog)
//
module channel_arbiter #(
  parameter int CH_NUM      = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int CH_WIDTH    = $clog2(CH_NUM),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_busy,
  input  logic [CH_NUM-1:0]            ch_ready,
  input  logic [CH_NUM-1:0]            ch_eop,
  output logic [CH_NUM-1:0]            ch_sel,
  input  logic [CH_NUM-1:0]            ch_sop,
  input  logic [CH_NUM-1:0]            ch_eop_d,
  input  logic [CH_NUM-1:0]            ch_valid,
  input  logic [CH_NUM*DATA_WIDTH-1:0] ch_data,
  input  logic [CH_NUM*4-1:0]          ch_bytes,
  input  logic [CH_NUM-1:0]            ch_error,
  output logic                         o_sop,
  output logic                         o_eop,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [3:0]                   o_bytes,
  output logic                         o_error,
  output logic [CH_WIDTH-1:0]          o_chan,
  output logic                         o_timeout
);

  // Elaboration-time parameter sanity checks.
  if (CH_NUM < 2 || CH_NUM > 16) begin : g_bad_ch_num
    $error("channel_arbiter: CH_NUM must be in 2..16");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("channel_arbiter: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t              state;
  logic [CH_WIDTH-1:0] ptr;       // last channel served
  logic [CH_WIDTH-1:0] sel_idx;   // channel currently granted
  logic [CH_WIDTH-1:0] win_idx;
  logic [CH_WIDTH-1:0] cand_idx;
  logic                win_found;

  logic                  sel_sop;
  logic                  sel_eop_d;
  logic                  sel_valid;
  logic                  sel_error;
  logic                  sel_eop;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [3:0]            sel_bytes;

  // Round-robin search: start one past the last served channel and wrap, so
  // the first ready channel found is the winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      cand_idx = CH_WIDTH'((int'(ptr) + k) % CH_NUM);
      if (!win_found && ch_ready[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Source mux for the granted channel, built from constant slices.
  always_comb begin
    sel_sop   = 1'b0;
    sel_eop_d = 1'b0;
    sel_valid = 1'b0;
    sel_error = 1'b0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    sel_bytes = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (sel_idx == CH_WIDTH'(i)) begin
        sel_sop   = ch_sop[i];
        sel_eop_d = ch_eop_d[i];
        sel_valid = ch_valid[i];
        sel_error = ch_error[i];
        sel_eop   = ch_eop[i];
        sel_data  = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_bytes = ch_bytes[i*4 +: 4];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;
  logic          to_hit;

  // The counter is 0 on the first XFER cycle, so hitting TIMEOUT_CYC-1 means
  // the grant has been held for TIMEOUT_CYC cycles when the release edge comes.
  assign to_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= CH_WIDTH'(CH_NUM - 1);
      sel_idx <= '0;
      ch_sel  <= '0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_bytes <= '0;
      o_error <= 1'b0;
      o_chan  <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt    <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          o_sop   <= 1'b0;
          o_eop   <= 1'b0;
          o_valid <= 1'b0;
          o_data  <= '0;
          o_bytes <= '0;
          o_error <= 1'b0;
          o_chan  <= '0;
          if (!i_busy && win_found) begin
            ch_sel  <= {{(CH_NUM-1){1'b0}}, 1'b1} << win_idx;
            sel_idx <= win_idx;
            state   <= XFER;
`ifdef ARB_TIMEOUT_EN
            to_cnt  <= '0;
`endif
          end else begin
            ch_sel <= '0;
          end
        end

        XFER: begin
          // Forward the granted channel's beat with one cycle of latency; the
          // eop beat is still forwarded on the edge that drops the grant.
          o_sop   <= sel_sop;
          o_eop   <= sel_eop_d;
          o_valid <= sel_valid;
          o_data  <= sel_data;
          o_bytes <= sel_bytes;
          o_error <= sel_error;
          o_chan  <= sel_idx;
          if (sel_eop) begin
            ch_sel <= '0;
            ptr    <= sel_idx;
            state  <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (to_hit) begin
            ch_sel    <= '0;
            ptr       <= sel_idx;
            state     <= IDLE;
            o_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        default: begin
          ch_sel <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
